// File: rtl/response_checker.sv
`default_nettype none
// ============================================================================
// Module   : response_checker
// Brief    : Sweeps all input vectors onto a small combinational DUT and
//            checks each settled response against a parameterised truth table.
// Revision : 1.0
// ============================================================================
module response_checker #(
  parameter int                  N_IN     = 3,
  parameter logic [2**N_IN-1:0]  EXPECTED = 8'h31,
  parameter int                  SETTLE   = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            y_in,
  output logic [N_IN-1:0] vec_out,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic [N_IN-1:0] first_fail,
  output logic            fail_valid
);

  localparam logic [1:0] c_st_idle   = 2'd0;
  localparam logic [1:0] c_st_apply  = 2'd1;
  localparam logic [1:0] c_st_sample = 2'd2;
  localparam logic [1:0] c_st_done   = 2'd3;

  localparam logic [3:0]      c_settle_last = 4'(SETTLE - 1);
  localparam logic [N_IN-1:0] c_last_vec    = '1;

  logic [1:0]      r_state;
  logic [3:0]      r_cnt;
  logic [N_IN-1:0] r_vec;
  logic [N_IN:0]   r_err;
  logic [N_IN-1:0] r_first;
  logic            r_fail_valid;
  logic            r_pass;
  logic            w_mismatch;

  // Case-inequality so an X/Z response is flagged rather than silently matched.
  assign w_mismatch = (y_in !== EXPECTED[r_vec]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= c_st_idle;
      r_cnt        <= '0;
      r_vec        <= '0;
      r_err        <= '0;
      r_first      <= '0;
      r_fail_valid <= 1'b0;
      r_pass       <= 1'b0;
    end else begin
      case (r_state)
        c_st_idle: begin
          if (start) begin
            r_vec        <= '0;
            r_err        <= '0;
            r_first      <= '0;
            r_fail_valid <= 1'b0;
            r_pass       <= 1'b0;
            r_cnt        <= '0;
            r_state      <= c_st_apply;
          end
        end
        c_st_apply: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt >= c_settle_last) begin
            r_state <= c_st_sample;
          end
        end
        c_st_sample: begin
          if (w_mismatch) begin
            r_err <= r_err + 1'b1;
            if (!r_fail_valid) begin
              r_first      <= r_vec;
              r_fail_valid <= 1'b1;
            end
          end
          if (r_vec == c_last_vec) begin
            r_state <= c_st_done;
          end else begin
            r_vec   <= r_vec + 1'b1;
            r_cnt   <= '0;
            r_state <= c_st_apply;
          end
        end
        c_st_done: begin
          r_pass  <= (r_err == '0);
          r_state <= c_st_idle;
        end
        default: r_state <= c_st_idle;
      endcase
    end
  end

  assign vec_out    = r_vec;
  assign busy       = (r_state != c_st_idle);
  assign done       = (r_state == c_st_done);
  assign pass       = r_pass;
  assign err_count  = r_err;
  assign first_fail = r_first;
  assign fail_valid = r_fail_valid;

endmodule
`default_nettype wire
